// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Contents: FSM state encoding, frame constants and the clocks-per-tick
// helper. The transmitter is expected to reuse the same helper.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE_C  = 3'd0;
  localparam logic [2:0] ST_START_C = 3'd1;
  localparam logic [2:0] ST_DATA_C  = 3'd2;
  localparam logic [2:0] ST_STOP_C  = 3'd3;
  localparam logic [2:0] ST_BREAK_C = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_START = ST_START_C,
    ST_DATA  = ST_DATA_C,
    ST_STOP  = ST_STOP_C,
    ST_BREAK = ST_BREAK_C
  } state_t;

  // Clocks per oversampling tick. The result must be at least 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle of the UART receiver.
// Signals: rx (serial line in), d_out (received byte), rx_done (byte strobe),
// framing_err (bad stop bit strobe), busy (FSM not idle), state (FSM debug).
// Handshake: rx_done is a valid-only strobe with no ready. It is high for
// exactly one clk and d_out is stable from that cycle until the next
// rx_done, so the consumer must capture d_out on or after the strobe. It
// cannot apply back-pressure.
// master = receiver (drives results), slave = line driver / consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       framing_err;
  logic       busy;
  state_t     state;

  modport master (input rx, output d_out, rx_done, framing_err, busy, state);
  modport slave  (output rx, input d_out, rx_done, framing_err, busy, state);
endinterface

// File: rtl/baud_tick_gen.sv
// Free-running oversampling tick generator.
// Ports: clk, reset (sync, active-high), tick (one clk high every DIV clks).
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Ports: clk, reset (sync, active-high), bus (uart_rx_if.master: rx in;
// d_out, rx_done, framing_err, busy and FSM state out).
// A start bit is confirmed at its middle, and then every data and stop bit
// is sampled 16 ticks later. A low stop bit raises framing_err. The FSM
// then parks in BREAK until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19200,
  parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
  input  logic         clk,
  input  logic         reset,
  uart_rx_if.master    bus
);
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

  logic tick;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer. It resets to the idle (high) line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] s_cnt_q, s_cnt_d;
  logic [2:0] n_q, n_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] d_out_q, d_out_d;
  logic       rx_done_q, rx_done_d;
  logic       ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_d       = n_q;
    sh_d      = sh_q;
    d_out_d   = d_out_q;
    rx_done_d = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          s_cnt_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s_q) begin
              s_cnt_d = '0;
              n_d     = '0;
              state_d = ST_DATA;
            end else begin
              state_d = ST_IDLE;  // glitch shorter than half a bit
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            sh_d    = {rx_s_q, sh_q[7:1]};  // LSB arrives first
            s_cnt_d = '0;
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_cnt_q == S_LAST) begin
            if (rx_s_q) begin
              d_out_d   = sh_q;
              rx_done_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_cnt_q   <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      d_out_q   <= '0;
      rx_done_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_q       <= n_d;
      sh_q      <= sh_d;
      d_out_q   <= d_out_d;
      rx_done_q <= rx_done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.d_out       = d_out_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.framing_err = ferr_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.state       = state_q;
endmodule
